// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: single-beat core accesses versus bounded DMA bursts,
// round-robin on ties, with core stall signalling through core_ready.
module dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  // state  | meaning
  // S_IDLE | no burst owner; core and DMA arbitrate round-robin each cycle
  // S_DMA  | DMA holds memory for the rest of its burst (up to MAX_BURST beats)
  typedef enum logic {S_IDLE, S_DMA} state_t;

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic             last_dma_q, last_dma_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             core_win, dma_win;
  logic             core_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      last_dma_q <= 1'b1;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dma_d = last_dma_q;
    beat_cnt_d = beat_cnt_q;
    core_win   = 1'b0;
    dma_win    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (core_req && (!dma_req || last_dma_q)) begin
          core_win   = 1'b1;
          last_dma_d = 1'b0;
        end else if (dma_req) begin
          dma_win    = 1'b1;
          last_dma_d = 1'b1;
          if (!(dma_last || MAX_BURST == 1)) begin
            beat_cnt_d = CNT_W'(1);
            state_d    = S_DMA;
          end
        end
      end
      S_DMA: begin
        if (dma_req) begin
          dma_win = 1'b1;
          // the beat that reaches MAX_BURST forces the release
          if (dma_last || beat_cnt_q == LAST_CNT) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d    = S_IDLE;
          beat_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // Reset gates every strobe combinationally so an async abort is immediate.
  always_comb begin
    core_gnt   = core_win & rst;
    dma_gnt    = dma_win & rst;
    core_ready = rst & (!core_req | core_gnt);
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (core_gnt) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_read  = !core_we;
      mem_write = core_we;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_read  = !dma_we;
      mem_write = dma_we;
    end
  end

  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign owner      = (state_q == S_DMA) ? 2'b10 : (last_dma_q ? 2'b00 : 2'b01);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// checked against a rule-level arbitration model and a reference memory image.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic [DW-1:0] core_rdata;
  logic          core_ready;
  logic          dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_ready(core_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_last(dma_last), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int checks = 0;
  int errors = 0;

  // model: burst ownership, beats used in it, whose turn a tie is, who won last
  bit m_in_burst;
  int m_beats;
  bit m_core_turn;
  bit m_core_last;
  int stall;
  bit g_core, g_dma;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_burst  = 1'b0;
    m_beats     = 0;
    m_core_turn = 1'b1;
    m_core_last = 1'b0;
    stall       = 0;
  endtask

  task automatic step(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input bit dreq, input bit dwe,
                      input logic [AW-1:0] daddr, input logic [DW-1:0] dwd, input bit dlast);
    bit ec, ed, ewr, erd;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic [1:0] eo;
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_last = dlast;
    ec = 1'b0; ed = 1'b0;
    if (m_in_burst) ed = dreq;
    else if (creq && (!dreq || m_core_turn)) ec = 1'b1;
    else if (dreq) ed = 1'b1;
    ea  = ec ? caddr : (ed ? daddr : '0);
    ew  = ec ? cwd : (ed ? dwd : '0);
    ewr = (ec && cwe) || (ed && dwe);
    erd = (ec && !cwe) || (ed && !dwe);
    eo  = m_in_burst ? 2'b10 : (m_core_last ? 2'b01 : 2'b00);
    @(negedge clk);
    chk("dma_gnt", 32'(dma_gnt), 32'(ed));
    chk("core_ready", 32'(core_ready), 32'(!creq || ec));
    chk("mem_write", 32'(mem_write), 32'(ewr));
    chk("mem_read", 32'(mem_read), 32'(erd));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_wdata", mem_wdata, ew);
    chk("owner", 32'(owner), 32'(eo));
    if (ec && !cwe) chk("core_rdata", core_rdata, ref_mem[caddr]);
    if (ed && !dwe) chk("dma_rdata", dma_rdata, ref_mem[daddr]);
    if (creq && !core_ready) stall++; else stall = 0;
    chk("stall_bound", 32'(stall <= MB), 32'd1);
    @(posedge clk);
    if (ewr) ref_mem[ea] = ew;
    if (ec) begin m_core_turn = 1'b0; m_core_last = 1'b1; end
    if (ed) begin m_core_turn = 1'b1; m_core_last = 1'b0; end
    if (m_in_burst) begin
      if (!dreq) m_in_burst = 1'b0;
      else begin
        m_beats++;
        if (dlast || m_beats >= MB) m_in_burst = 1'b0;
      end
    end else if (ed) begin
      m_beats    = 1;
      m_in_burst = !(dlast || MB == 1);
    end
    g_core = ec; g_dma = ed;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    core_req = 1'b1; dma_req = 1'b1; core_we = 1'b0; dma_we = 1'b1;
    core_addr = 10'h3ff; dma_addr = 10'h2aa; dma_wdata = 32'h5a5a5a5a;
    #1;
    chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("rst_core_ready", 32'(core_ready), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int dbeat;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[10'h010]     = 32'hDEADBEEF;
    ref_mem[10'h010] = 32'hDEADBEEF;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // core-only read
    step(1, 0, 10'h010, 0, 0, 0, 0, 0, 0);
    chk("core_first_read_granted", 32'(g_core), 32'd1);

    // 4-beat DMA write burst, then core reads the data back
    for (int k = 0; k < 4; k++)
      step(0, 0, 0, 0, 1, 1, AW'(10'h100 + k), DW'(k + 1), k == 3);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, AW'(10'h100 + k), 0, 0, 0, 0, 0, 0);
      chk("burst_readback_ref", ref_mem[10'h100 + k], DW'(k + 1));
    end

    // contention right after reset: core first, then the 5-beat burst, then core
    do_reset();
    dbeat = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 10'h010, 0, dbeat < 5, 1, AW'(10'h200 + dbeat), DW'(32'h50 + dbeat), dbeat == 4);
      if (c == 0) chk("contention_core_first", 32'(g_core), 32'd1);
      if (c == 6) chk("core_after_burst", 32'(g_core), 32'd1);
      if (g_dma) dbeat++;
    end

    // forced release: DMA never asserts last, core always requesting
    for (int i = 0; i < 40; i++)
      step(1, 0, AW'($urandom_range(0, 15)), 0, 1, 1, AW'(10'h300 + (i % 64)), DW'(i), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // DMA drops its request on beat 3 while the core waits
    step(0, 0, 0, 0, 1, 0, 10'h100, 0, 0);
    step(0, 0, 0, 0, 1, 0, 10'h101, 0, 0);
    step(1, 0, 10'h102, 0, 0, 0, 0, 0, 0);
    chk("bubble_no_core", 32'(g_core), 32'd0);
    step(1, 0, 10'h102, 0, 0, 0, 0, 0, 0);
    chk("core_after_bubble", 32'(g_core), 32'd1);

    // async reset in the middle of beat 5
    for (int k = 0; k < 4; k++)
      step(0, 0, 0, 0, 1, 1, AW'(10'h180 + k), DW'(32'hA0 + k), 0);
    core_req = 1'b1; core_we = 1'b0; core_addr = 10'h010;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h184; dma_wdata = 32'hA4; dma_last = 1'b0;
    #2;
    chk("beat5_gnt_before_rst", 32'(dma_gnt), 32'd1);
    chk("beat5_write_before_rst", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_core_ready", 32'(core_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    step(1, 0, 10'h184, 0, 1, 1, 10'h185, 32'hA5, 0);
    chk("post_abort_core_first", 32'(g_core), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 4) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
